cvxif_copro_arbiter: RTL and testbench

//   Shares one CVXIF-style complex-number coprocessor between NREQ issuing requesters.

---
 rtl/cvxif_copro_arbiter.sv | 148 ++++++++++++++
 tb/tb_cvxif_copro_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_copro_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cvxif_copro_arbiter : round-robin share of one CVXIF coprocessor, 1 txn in flight
// Revision 1.0
// ---------------------------------------------------------------------------
module cvxif_copro_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_issue_valid,
  output logic [NREQ-1:0]   req_issue_ready,
  input  logic [NREQ*32-1:0] req_issue_instr,
  output logic [NREQ-1:0]   req_issue_resp_accept,
  output logic [1:0]        req_issue_resp_regrd,
  input  logic [NREQ-1:0]   req_register_valid,
  output logic [NREQ-1:0]   req_register_ready,
  input  logic [NREQ*64-1:0] req_register_rs,
  input  logic [NREQ*2-1:0] req_register_rs_valid,
  output logic [NREQ-1:0]   req_result_valid,
  input  logic [NREQ-1:0]   req_result_ready,
  output logic [31:0]       req_result_data,
  output logic              co_issue_valid,
  input  logic              co_issue_ready,
  output logic [31:0]       co_issue_instr,
  input  logic              co_issue_resp_accept,
  input  logic [1:0]        co_issue_resp_regrd,
  output logic              co_register_valid,
  input  logic              co_register_ready,
  output logic [63:0]       co_register_rs,
  output logic [1:0]        co_register_rs_valid,
  input  logic              co_result_valid,
  output logic              co_result_ready,
  input  logic [31:0]       co_result_data,
  output logic              busy,
  output logic [IDW-1:0]    owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_REGS   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [31:0]     instr_q, instr_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  int              grant_pos;

  // Walk the ring from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_pos   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      grant_pos = (int'(rr_ptr_q) + k) % NREQ;
      if (req_issue_valid[grant_pos]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(grant_pos);
      end
    end
  end

  always_comb begin
    state_d               = state_q;
    rr_ptr_d              = rr_ptr_q;
    owner_d               = owner_q;
    instr_d               = instr_q;
    req_issue_ready       = '0;
    req_issue_resp_accept = '0;
    req_register_ready    = '0;
    req_result_valid      = '0;
    co_issue_valid        = 1'b0;
    co_register_valid     = 1'b0;
    co_result_ready       = 1'b0;
    req_issue_resp_regrd  = co_issue_resp_regrd;
    req_result_data       = co_result_data;
    co_issue_instr        = instr_q;
    co_register_rs        = req_register_rs[{owner_q, 6'b0} +: 64];
    co_register_rs_valid  = req_register_rs_valid[{owner_q, 1'b0} +: 2];
    busy                  = (state_q != S_IDLE);
    owner                 = owner_q;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          instr_d = req_issue_instr[{grant_idx, 5'b0} +: 32];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        co_issue_valid                 = 1'b1;
        req_issue_ready[owner_q]       = co_issue_ready;
        req_issue_resp_accept[owner_q] = co_issue_ready & co_issue_resp_accept;
        if (co_issue_ready) begin
          if (co_issue_resp_accept) begin
            state_d = S_REGS;
          end else begin
            state_d  = S_IDLE;
            rr_ptr_d = owner_q;
          end
        end else if (!req_issue_valid[owner_q]) begin
          // Requester withdrew: no service happened, so priority does not rotate.
          state_d = S_IDLE;
        end
      end
      S_REGS: begin
        co_register_valid           = req_register_valid[owner_q];
        req_register_ready[owner_q] = co_register_ready;
        if (req_register_valid[owner_q] && co_register_ready) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        req_result_valid[owner_q] = co_result_valid;
        co_result_ready           = req_result_ready[owner_q];
        if (co_result_valid && req_result_ready[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      owner_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      instr_q  <= instr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_copro_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cvxif_copro_arbiter : self-checking bench, vector table plus transaction sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cvxif_copro_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_issue_valid, req_issue_ready, req_issue_resp_accept;
  logic [NREQ*32-1:0] req_issue_instr;
  logic [1:0]        req_issue_resp_regrd;
  logic [NREQ-1:0]   req_register_valid, req_register_ready;
  logic [NREQ*64-1:0] req_register_rs;
  logic [NREQ*2-1:0] req_register_rs_valid;
  logic [NREQ-1:0]   req_result_valid, req_result_ready;
  logic [31:0]       req_result_data;
  logic              co_issue_valid, co_issue_ready, co_issue_resp_accept;
  logic [31:0]       co_issue_instr;
  logic [1:0]        co_issue_resp_regrd;
  logic              co_register_valid, co_register_ready;
  logic [63:0]       co_register_rs;
  logic [1:0]        co_register_rs_valid;
  logic              co_result_valid, co_result_ready;
  logic [31:0]       co_result_data;
  logic              busy;
  logic [IDW-1:0]    owner;

  cvxif_copro_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_issue_valid(req_issue_valid), .req_issue_ready(req_issue_ready),
    .req_issue_instr(req_issue_instr), .req_issue_resp_accept(req_issue_resp_accept),
    .req_issue_resp_regrd(req_issue_resp_regrd),
    .req_register_valid(req_register_valid), .req_register_ready(req_register_ready),
    .req_register_rs(req_register_rs), .req_register_rs_valid(req_register_rs_valid),
    .req_result_valid(req_result_valid), .req_result_ready(req_result_ready),
    .req_result_data(req_result_data),
    .co_issue_valid(co_issue_valid), .co_issue_ready(co_issue_ready),
    .co_issue_instr(co_issue_instr), .co_issue_resp_accept(co_issue_resp_accept),
    .co_issue_resp_regrd(co_issue_resp_regrd),
    .co_register_valid(co_register_valid), .co_register_ready(co_register_ready),
    .co_register_rs(co_register_rs), .co_register_rs_valid(co_register_rs_valid),
    .co_result_valid(co_result_valid), .co_result_ready(co_result_ready),
    .co_result_data(co_result_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0]    instr_tb [NREQ];
  logic [63:0]    rs_tb    [NREQ];
  logic [IDW-1:0] exp_q [$];

  typedef struct {
    logic [NREQ-1:0] req;
    logic [IDW-1:0]  exp_owner;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_instr"}, co_issue_instr, 0);
    chk({tag, "_valids"}, {co_issue_valid, co_register_valid, co_result_ready}, 0);
    chk({tag, "_req_out"}, {req_issue_ready, req_issue_resp_accept,
                            req_register_ready, req_result_valid}, 0);
  endtask

  // One full transaction; optional stalls in REGS/RESULT, or a reset while in RESULT.
  task automatic full_txn(input logic [NREQ-1:0] reqs, input logic [IDW-1:0] exp_owner,
                          input logic [31:0] res, input int reg_wait, input int res_wait,
                          input bit abort);
    int lat;
    logic [IDW-1:0] o;
    req_issue_valid = reqs;
    exp_q.push_back(exp_owner);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!co_issue_valid && lat < 8);
    #1;
    chk("issue_latency", lat, 1);
    o = exp_q.pop_front();
    if (!co_issue_valid) return;
    chk("grant_owner", owner, o);
    chk("issue_instr", co_issue_instr, instr_tb[o]);
    chk("busy_issue", busy, 1);
    co_issue_ready = 1'b1; co_issue_resp_accept = 1'b1; co_issue_resp_regrd = 2'b10;
    #1;
    chk("issue_ready", req_issue_ready, 2'b01 << o);
    chk("issue_accept", req_issue_resp_accept, 2'b01 << o);
    chk("issue_regrd", req_issue_resp_regrd, 2'b10);
    step();
    req_issue_valid[o] = 1'b0;
    co_issue_ready = 1'b0; co_issue_resp_accept = 1'b0;
    req_register_valid = 2'b01 << o;
    req_register_rs_valid = '1;
    co_register_ready = 1'b0;
    for (int i = 0; i < reg_wait; i++) begin
      #1;
      chk("regs_stall_valid", co_register_valid, 1);
      chk("regs_stall_ready", req_register_ready, 0);
      step();
    end
    co_register_ready = 1'b1;
    #1;
    chk("regs_ready", req_register_ready, 2'b01 << o);
    chk("regs_rs", co_register_rs, rs_tb[o]);
    step();
    req_register_valid = '0; co_register_ready = 1'b0;
    co_result_valid = 1'b1; co_result_data = res; req_result_ready = '0;
    if (abort) begin
      rst_n = 1'b0;
      step();
      co_result_valid = 1'b0;
      #1;
      chk_all_idle("abort");
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < res_wait; i++) begin
      #1;
      chk("res_stall_ready", co_result_ready, 0);
      chk("res_stall_valid", req_result_valid, 2'b01 << o);
      step();
    end
    req_result_ready = '1;
    #1;
    chk("result_valid", req_result_valid, 2'b01 << o);
    chk("result_data", req_result_data, res);
    chk("result_co_ready", co_result_ready, 1);
    step();
    co_result_valid = 1'b0; req_result_ready = '0;
    #1;
    chk("busy_bubble", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IDW-1:0] o;
    instr_tb[0] = 32'h0000_007B;
    instr_tb[1] = 32'h0000_1C2B;
    rs_tb[0]    = 64'h1111_2222_3333_4444;
    rs_tb[1]    = 64'hAAAA_BBBB_CCCC_DDDD;
    req_issue_instr = {instr_tb[1], instr_tb[0]};
    req_register_rs = {rs_tb[1], rs_tb[0]};
    rst_n = 1'b0;
    req_issue_valid = '0; req_register_valid = '0; req_register_rs_valid = '0;
    req_result_ready = '0;
    co_issue_ready = 1'b0; co_issue_resp_accept = 1'b0; co_issue_resp_regrd = 2'b00;
    co_register_ready = 1'b0; co_result_valid = 1'b0; co_result_data = '0;

    // Starting from rr_ptr = 0 (after the back-to-back group); each row is rejected.
    vecs[0] = '{req: 2'b11, exp_owner: 1'b1};
    vecs[1] = '{req: 2'b11, exp_owner: 1'b0};
    vecs[2] = '{req: 2'b01, exp_owner: 1'b0};
    vecs[3] = '{req: 2'b10, exp_owner: 1'b1};
    vecs[4] = '{req: 2'b10, exp_owner: 1'b1};
    vecs[5] = '{req: 2'b11, exp_owner: 1'b0};

    step(); step();
    #1;
    chk_all_idle("reset");
    rst_n = 1'b1;

    full_txn(2'b01, 1'b0, 32'h0005_0003, 0, 0, 1'b0);
    full_txn(2'b11, 1'b1, 32'h0000_1234, 0, 0, 1'b0);
    full_txn(2'b11, 1'b0, 32'h00AB_CDEF, 0, 0, 1'b0);

    // Owner withdraws in ISSUE: priority stays with rr_ptr = 0.
    req_issue_valid = 2'b10;
    step(); #1;
    chk("drop_owner", owner, 1);
    chk("drop_issue_valid", co_issue_valid, 1);
    req_issue_valid = '0;
    step(); #1;
    chk("drop_idle", busy, 0);

    for (int i = 0; i < 6; i++) begin
      req_issue_valid = vecs[i].req;
      co_issue_ready = 1'b0;
      exp_q.push_back(vecs[i].exp_owner);
      step(); #1;
      o = exp_q.pop_front();
      chk("tbl_owner", owner, o);
      chk("tbl_issue_valid", co_issue_valid, 1);
      chk("tbl_ready_wait", req_issue_ready, 0);
      co_issue_ready = 1'b1; co_issue_resp_accept = 1'b0;
      #1;
      chk("tbl_reject_ready", req_issue_ready, 2'b01 << o);
      chk("tbl_reject_accept", req_issue_resp_accept, 0);
      step();
      req_issue_valid = '0; co_issue_ready = 1'b0;
      #1;
      chk("tbl_idle", busy, 0);
    end

    full_txn(2'b01, 1'b0, 32'hDEAD_0001, 5, 3, 1'b0);
    full_txn(2'b10, 1'b1, 32'hDEAD_0002, 0, 0, 1'b1);
    full_txn(2'b11, 1'b0, 32'hDEAD_0003, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
